// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_receiver_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 1 so an
// idle-high line is not seen as a start edge while coming out of reset.
module sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART byte receiver: mid-bit sampling driven by a half-bit counter,
// one-cycle valid strobe when a frame with a good stop bit completes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int RECEIVER_PERIOD = 646
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in,
  output logic [7:0] out,
  output logic       valid
);

  localparam int CNT_W = $clog2(2 * RECEIVER_PERIOD) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(RECEIVER_PERIOD - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * RECEIVER_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic in_s;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           out_q,   out_d;
  logic                 valid_q, valid_d;

  sync2 u_sync_in (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (in),
    .q_o  (in_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!in_s) begin
          state_d = START;
        end
      end

      // A start bit that is high again at its midpoint was a glitch.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (in_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = in_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A low stop bit is a framing error: the byte is dropped silently.
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (in_s == STOP_LEVEL) begin
            out_d   = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a fast instance (R=2) for the functional
// cases and a default-rate instance (R=646) for the "OK\n" sequence.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int R_S = 2;
  localparam int R_B = 646;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       din_s = 1'b1;
  logic       din_b = 1'b1;
  logic [7:0] out_s, out_b;
  logic       valid_s, valid_b;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int sc;

  logic [7:0] q_s[$];
  logic [7:0] q_b[$];
  int         c_s[$];

  uart_receiver #(.RECEIVER_PERIOD(R_S)) dut_s (
    .clk   (clk),
    .rstn  (rstn),
    .in    (din_s),
    .out   (out_s),
    .valid (valid_s)
  );

  uart_receiver #(.RECEIVER_PERIOD(R_B)) dut_b (
    .clk   (clk),
    .rstn  (rstn),
    .in    (din_b),
    .out   (out_b),
    .valid (valid_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_s) begin
      q_s.push_back(out_s);
      c_s.push_back(cyc);
    end
    if (valid_b) q_b.push_back(out_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input bit big, input logic v);
    if (big) din_b = v;
    else     din_s = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge that ends the stop bit.
  task automatic send(input bit big, input logic [7:0] b, input logic stop_bit,
                      output int start_cyc);
    int bt;
    bt = big ? 2 * R_B : 2 * R_S;
    drive(big, 1'b0);
    start_cyc = cyc;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(big, b[i]);
      repeat (bt) @(negedge clk);
    end
    drive(big, stop_bit);
    repeat (bt) @(negedge clk);
    drive(big, 1'b1);
  endtask

  function automatic logic [31:0] qget(input int i);
    return (q_s.size() > i) ? {24'h0, q_s[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qbget(input int i);
    return (q_b.size() > i) ? {24'h0, q_b[i]} : 32'hDEAD;
  endfunction

  initial begin
    int st;
    idle(3);
    chk("reset_out_s", {24'h0, out_s}, 32'h00);
    chk("reset_valid_s", {31'h0, valid_s}, 32'h0);
    chk("reset_out_b", {24'h0, out_b}, 32'h00);
    rstn = 1'b1;
    idle(5);

    // Single 0x55 frame with exact latency.
    q_s.delete(); c_s.delete();
    send(1'b0, 8'h55, 1'b1, st);
    idle(10);
    chk("x55_count", q_s.size(), 1);
    chk("x55_data", qget(0), 32'h55);
    chk("x55_latency", (c_s.size() > 0) ? c_s[0] : -1, st + 2 + 19 * R_S + 1);

    // Back-to-back frames.
    q_s.delete();
    send(1'b0, 8'h00, 1'b1, st);
    send(1'b0, 8'hFF, 1'b1, st);
    send(1'b0, 8'hA3, 1'b1, st);
    idle(10);
    chk("b2b_count", q_s.size(), 3);
    chk("b2b_0", qget(0), 32'h00);
    chk("b2b_1", qget(1), 32'hFF);
    chk("b2b_2", qget(2), 32'hA3);

    // One-cycle glitch, then a real frame.
    q_s.delete();
    din_s = 1'b0;
    idle(1);
    din_s = 1'b1;
    idle(12);
    chk("glitch_none", q_s.size(), 0);
    send(1'b0, 8'h3C, 1'b1, st);
    idle(10);
    chk("after_glitch_count", q_s.size(), 1);
    chk("after_glitch_data", qget(0), 32'h3C);

    // Framing error keeps the previous byte.
    q_s.delete();
    send(1'b0, 8'h81, 1'b0, st);
    idle(12);
    chk("frame_err_none", q_s.size(), 0);
    chk("frame_err_hold", {24'h0, out_s}, 32'h3C);
    send(1'b0, 8'h12, 1'b1, st);
    idle(10);
    chk("after_ferr_count", q_s.size(), 1);
    chk("after_ferr_data", qget(0), 32'h12);

    // Reset in the middle of data bit 4.
    q_s.delete();
    fork
      send(1'b0, 8'h77, 1'b1, sc);
      begin
        repeat (2 * R_S * 5 + R_S) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_out", {24'h0, out_s}, 32'h00);
        chk("rst_mid_valid", {31'h0, valid_s}, 32'h0);
      end
    join
    idle(4);
    rstn = 1'b1;
    idle(6);
    chk("rst_mid_none", q_s.size(), 0);
    send(1'b0, 8'h77, 1'b1, st);
    idle(10);
    chk("resend_count", q_s.size(), 1);
    chk("resend_out", {24'h0, out_s}, 32'h77);

    // Default rate: "OK\n".
    q_b.delete();
    send(1'b1, 8'h4F, 1'b1, st);
    send(1'b1, 8'h4B, 1'b1, st);
    send(1'b1, 8'h0A, 1'b1, st);
    idle(20);
    chk("ok_count", q_b.size(), 3);
    chk("ok_0", qbget(0), 32'h4F);
    chk("ok_1", qbget(1), 32'h4B);
    chk("ok_2", qbget(2), 32'h0A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
